// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_pkg
//  Description : Shared types and constants for the loadable instruction
//                memory: FSM state encoding, NOP word and opcode field helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_mem_pkg;

    // Controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Word returned for any fetch outside the loaded image
    localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;

    // Opcode field lives in the low bits of an instruction word
    localparam int          c_OPC_W    = 5;
    localparam logic [4:0]  c_OP_HALT  = 5'd18;

    // Extract the opcode field of an instruction word
    function automatic logic [c_OPC_W-1:0] f_opcode(input logic [31:0] word);
        return word[c_OPC_W-1:0];
    endfunction

    // True when the word is a HALT instruction
    function automatic logic f_is_halt(input logic [31:0] word);
        return (f_opcode(word) == c_OP_HALT);
    endfunction

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : instr_ram_sp
//  Description : DEPTH x DATA_W RAM with one synchronous write port and one
//                synchronous, registered read port. Read data only changes
//                on a read enable so the last read word is held.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_ram_sp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 151,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port: store a word when the loader's write is accepted
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered read, result held between enables
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : instr_ram_sp
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loadable
//  Description : Runtime-loadable instruction memory for the fetch stage.
//                A loader streams words in over a valid/ready port; the core
//                then fetches with 1-cycle registered reads. Fetches outside
//                the loaded image return NOP_WORD with addr_fault set.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 151,
    parameter int                ADDR_W     = 32,
    parameter int                START_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(c_NOP_WORD),
    localparam int               IDX_W      = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    // loader port
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_full,
    output logic [IDX_W:0]    load_count,
    // fetch port
    output logic              fetch_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instrucao,
    output logic              instr_valid,
    output logic              addr_fault
);

    localparam logic [IDX_W-1:0] c_PTR_START = IDX_W'(START_ADDR);
    localparam logic [IDX_W-1:0] c_PTR_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] c_PTR_ONE   = IDX_W'(1);
    localparam logic [IDX_W:0]   c_CNT_ONE   = (IDX_W + 1)'(1);
    localparam logic [ADDR_W:0]  c_ADDR_LO   = (ADDR_W + 1)'(START_ADDR);

    state_t            r_state;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W:0]    r_load_count;
    logic              r_load_full;
    logic              r_load_ready;
    logic              r_fetch_ready;
    logic              r_instr_valid;
    logic              r_addr_fault;
    logic              r_hit;

    logic              w_load_acc;
    logic              w_fetch_acc;
    logic [ADDR_W:0]   w_addr_ext;
    logic [ADDR_W:0]   w_addr_hi;
    logic              w_hit;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;

    // load_start takes precedence over anything presented in the same cycle
    assign w_load_acc  = r_load_ready  & load_valid & ~load_start;
    assign w_fetch_acc = r_fetch_ready & fetch_req  & ~load_start;

    // Range check on the full fetch address, one extra bit so the upper
    // bound of the image can never wrap
    assign w_addr_ext = {1'b0, fetch_addr};
    assign w_addr_hi  = c_ADDR_LO + {{(ADDR_W - IDX_W){1'b0}}, r_load_count};
    assign w_hit      = (w_addr_ext >= c_ADDR_LO) && (w_addr_ext < w_addr_hi);

    // Only touch the RAM read port for addresses inside the image
    assign w_ram_re   = w_fetch_acc & w_hit;

    instr_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_load_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (load_data),
        .i_re    (w_ram_re),
        .i_raddr (fetch_addr[IDX_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // Controller FSM with load counters and registered port flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= c_PTR_START;
            r_load_count  <= '0;
            r_load_full   <= 1'b0;
            r_load_ready  <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_instr_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
            r_hit         <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_acc;
            r_addr_fault  <= w_fetch_acc & ~w_hit;
            if (w_fetch_acc) begin
                r_hit <= w_hit;
            end

            if (load_start) begin
                r_state       <= S_LOAD;
                r_wr_ptr      <= c_PTR_START;
                r_load_count  <= '0;
                r_load_full   <= 1'b0;
                r_load_ready  <= 1'b1;
                r_fetch_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_load_ready  <= 1'b0;
                        r_fetch_ready <= 1'b0;
                    end
                    S_LOAD: begin
                        if (w_load_acc) begin
                            r_wr_ptr     <= r_wr_ptr + c_PTR_ONE;
                            r_load_count <= r_load_count + c_CNT_ONE;
                            if (load_last) begin
                                r_state       <= S_RUN;
                                r_load_ready  <= 1'b0;
                                r_fetch_ready <= 1'b1;
                            end else if (r_wr_ptr == c_PTR_LAST) begin
                                // Last slot written without load_last: image truncated
                                r_state       <= S_RUN;
                                r_load_full   <= 1'b1;
                                r_load_ready  <= 1'b0;
                                r_fetch_ready <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        r_load_ready  <= 1'b0;
                        r_fetch_ready <= 1'b1;
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_load_ready  <= 1'b0;
                        r_fetch_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign load_full   = r_load_full;
    assign load_count  = r_load_count;
    assign fetch_ready = r_fetch_ready;
    assign instr_valid = r_instr_valid;
    assign addr_fault  = r_addr_fault;

    // Both select and RAM data are registers that only move on a fetch,
    // so the word is held while instr_valid is low
    assign instrucao   = r_hit ? w_ram_rdata : NOP_WORD;

endmodule : instr_mem_loadable
`default_nettype wire
